// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and buffer entry type for the register writeback unit
package wb_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 2;

    // One pending register-file write: destination register and the value to store.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// rtl/reg_writeback_unit_if.sv - request, register-file and busy signals of the writeback unit (bypass ports under WB_BYPASS_EN)
interface reg_writeback_unit_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic [(1<<ADDR_W)-1:0] busy_mask;
    logic [CNT_W-1:0]  pending_count;
`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] query_rd_one;
    logic [ADDR_W-1:0] query_rd_two;
    logic              fwd_hit_one;
    logic              fwd_hit_two;
    logic [DATA_W-1:0] fwd_data_one;
    logic [DATA_W-1:0] fwd_data_two;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output query_rd_one, query_rd_two,
        input  alu_ready, mem_ready, RegWrite, write_register, write_data,
        input  busy_mask, pending_count,
        input  fwd_hit_one, fwd_hit_two, fwd_data_one, fwd_data_two
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  query_rd_one, query_rd_two,
        output alu_ready, mem_ready, RegWrite, write_register, write_data,
        output busy_mask, pending_count,
        output fwd_hit_one, fwd_hit_two, fwd_data_one, fwd_data_two
    );
`else
    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, RegWrite, write_register, write_data,
        input  busy_mask, pending_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, RegWrite, write_register, write_data,
        output busy_mask, pending_count
    );
`endif

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO of pending writeback entries
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_entry_o,
    output logic [PTR_W-1:0] head_ptr_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);
    // A full buffer refuses a push even when a pop frees a slot in the same cycle.
    assign do_push      = push_i & ~full_o;
    assign do_pop       = pop_i & ~empty_o;
    assign head_entry_o = mem_q[rd_ptr_q];
    assign head_ptr_o   = rd_ptr_q;
    assign entries_o    = mem_q;
    assign count_o      = count_q;

    // Next pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset discards every pending entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - register-file write initiator with load-priority arbitration, busy mask, optional WB_BYPASS_EN forwarding
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2
) (
    input logic                 CLK,
    input logic                 reset,
    reg_writeback_unit_if.slave wb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NREG  = 1 << ADDR_W;

    wb_entry_t         push_entry, head_entry;
    wb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0]   busy;

    // Loads win arbitration; readies depend only on the registered occupancy and mem_valid.
    assign wb.mem_ready = ~full;
    assign wb.alu_ready = ~full & ~wb.mem_valid;
    assign push = (wb.mem_valid & ~full) | (wb.alu_valid & ~full & ~wb.mem_valid);

    // Select which requester's entry enters the buffer this cycle.
    always_comb begin
        push_entry = '{rd: wb.alu_rd, data: wb.alu_data};
        if (wb.mem_valid) push_entry = '{rd: wb.mem_rd, data: wb.mem_data};
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (CLK),
        .rst_i        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (~empty),
        .head_entry_o (head_entry),
        .head_ptr_o   (head_ptr),
        .entries_o    (entries),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    // Output stage loads the head whenever the buffer holds anything; address/data hold otherwise.
    always_comb begin
        regwrite_d = ~empty;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;
        if (!empty) begin
            wr_reg_d  = head_entry.rd;
            wr_data_d = head_entry.data;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge CLK) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wb.RegWrite       = regwrite_q;
    assign wb.write_register = wr_reg_q;
    assign wb.write_data     = wr_data_q;
    assign wb.pending_count  = count;
    assign wb.busy_mask      = busy;

    // Busy mask: every occupied buffer slot plus the output stage while it is writing.
    always_comb begin
        logic [PTR_W-1:0] idx;
        busy = '0;
        if (regwrite_q) busy[wr_reg_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) busy[entries[idx].rd] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding: scan oldest to youngest so the youngest matching write is what remains.
    always_comb begin
        logic [PTR_W-1:0] idx;
        wb.fwd_hit_one  = 1'b0;
        wb.fwd_hit_two  = 1'b0;
        wb.fwd_data_one = '0;
        wb.fwd_data_two = '0;
        if (regwrite_q && wr_reg_q == wb.query_rd_one) begin
            wb.fwd_hit_one  = 1'b1;
            wb.fwd_data_one = wr_data_q;
        end
        if (regwrite_q && wr_reg_q == wb.query_rd_two) begin
            wb.fwd_hit_two  = 1'b1;
            wb.fwd_data_two = wr_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (entries[idx].rd == wb.query_rd_one) begin
                    wb.fwd_hit_one  = 1'b1;
                    wb.fwd_data_one = entries[idx].data;
                end
                if (entries[idx].rd == wb.query_rd_two) begin
                    wb.fwd_hit_two  = 1'b1;
                    wb.fwd_data_two = entries[idx].data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - self-checking bench for reg_writeback_unit against a queue-based model
module tb_reg_writeback_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct {
        int rd;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    wr_t  m_q[$];
    bit   m_rw;
    int   m_wr, m_wd;
    wr_t  obs[$];

    always #5 clk = ~clk;

    reg_writeback_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) wb ();

    reg_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .reset (reset),
        .wb    (wb)
    );

    function automatic logic [3:0] exp_busy();
        logic [3:0] m = '0;
        foreach (m_q[i]) m[m_q[i].rd] = 1'b1;
        if (m_rw) m[m_wr] = 1'b1;
        return m;
    endfunction

    function automatic void exp_fwd(input int q, output bit hit, output int data);
        hit  = 0;
        data = 0;
        if (m_rw && m_wr == q) begin hit = 1; data = m_wd; end
        foreach (m_q[i]) if (m_q[i].rd == q) begin hit = 1; data = m_q[i].data; end
    endfunction

    task automatic set_inputs(bit av, int ard, int ad, bit mv, int mrd, int md);
        wb.alu_valid = av;
        wb.alu_rd    = ADDR_W'(ard);
        wb.alu_data  = DATA_W'(ad);
        wb.mem_valid = mv;
        wb.mem_rd    = ADDR_W'(mrd);
        wb.mem_data  = DATA_W'(md);
    endtask

    // One clock of stimulus: drive after the falling edge, step the model at the rising edge,
    // compare every output against the model at the next falling edge.
    task automatic cycle(bit av, int ard, int ad, bit mv, int mrd, int md);
        bit  er_m, er_a, acc_m, acc_a, h;
        int  d;
        wr_t e;
        set_inputs(av, ard, ad, mv, mrd, md);
        #1;
        er_m = (m_q.size() < DEPTH);
        er_a = er_m && !mv;
        checks++;
        if (wb.mem_ready !== er_m) begin
            errors++; $display("FAIL mem_ready got=%0b exp=%0b", wb.mem_ready, er_m);
        end
        checks++;
        if (wb.alu_ready !== er_a) begin
            errors++; $display("FAIL alu_ready got=%0b exp=%0b", wb.alu_ready, er_a);
        end
        acc_m = mv && er_m;
        acc_a = av && er_a;
        @(posedge clk);
        if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_rw = 1; m_wr = e.rd; m_wd = e.data;
        end else begin
            m_rw = 0;
        end
        if (acc_m)      m_q.push_back('{mrd, md});
        else if (acc_a) m_q.push_back('{ard, ad});
        @(negedge clk);
        checks++;
        if (wb.RegWrite !== m_rw) begin
            errors++; $display("FAIL RegWrite got=%0b exp=%0b", wb.RegWrite, m_rw);
        end
        checks++;
        if (wb.write_register !== ADDR_W'(m_wr) || wb.write_data !== DATA_W'(m_wd)) begin
            errors++; $display("FAIL write_port got=%0d/%0h exp=%0d/%0h",
                               wb.write_register, wb.write_data, m_wr, m_wd);
        end
        checks++;
        if (wb.busy_mask !== exp_busy()) begin
            errors++; $display("FAIL busy_mask got=%b exp=%b", wb.busy_mask, exp_busy());
        end
        checks++;
        if (wb.pending_count !== CNT_W'(m_q.size())) begin
            errors++; $display("FAIL pending_count got=%0d exp=%0d", wb.pending_count, m_q.size());
        end
`ifdef WB_BYPASS_EN
        exp_fwd(int'(wb.query_rd_one), h, d);
        checks++;
        if (wb.fwd_hit_one !== h || wb.fwd_data_one !== DATA_W'(d)) begin
            errors++; $display("FAIL fwd_one got=%0b/%0h exp=%0b/%0h", wb.fwd_hit_one, wb.fwd_data_one, h, d);
        end
        exp_fwd(int'(wb.query_rd_two), h, d);
        checks++;
        if (wb.fwd_hit_two !== h || wb.fwd_data_two !== DATA_W'(d)) begin
            errors++; $display("FAIL fwd_two got=%0b/%0h exp=%0b/%0h", wb.fwd_hit_two, wb.fwd_data_two, h, d);
        end
`else
        h = 0; d = 0;
`endif
        if (wb.RegWrite === 1'b1) obs.push_back('{int'(wb.write_register), int'(wb.write_data)});
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        m_q.delete(); m_rw = 0; m_wr = 0; m_wd = 0;
        @(negedge clk);
        reset = 1'b0;
        obs.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wb.write_register !== '0 || wb.write_data !== '0) begin
            errors++; $display("FAIL reset_port got=%0d/%0h exp=0/0", wb.write_register, wb.write_data);
        end
        idle(5);
        checks++;
        if (wb.RegWrite !== 1'b0 || wb.busy_mask !== 4'b0000 || wb.pending_count !== '0) begin
            errors++; $display("FAIL reset_idle got=%0b/%b/%0d exp=0/0000/0",
                               wb.RegWrite, wb.busy_mask, wb.pending_count);
        end
    endtask

    task automatic test_latency();
        do_reset();
        cycle(1, 2, 'h5A, 0, 0, 0);
        checks++;
        if (wb.busy_mask !== 4'b0100 || wb.RegWrite !== 1'b0) begin
            errors++; $display("FAIL lat_n got=%b/%0b exp=0100/0", wb.busy_mask, wb.RegWrite);
        end
        idle(1);
        checks++;
        if (wb.RegWrite !== 1'b1 || wb.write_register !== 2'd2 || wb.write_data !== 8'h5A) begin
            errors++; $display("FAIL lat_n1 got=%0b/%0d/%0h exp=1/2/5a",
                               wb.RegWrite, wb.write_register, wb.write_data);
        end
        idle(1);
        checks++;
        if (wb.busy_mask !== 4'b0000 || wb.RegWrite !== 1'b0) begin
            errors++; $display("FAIL lat_n2 got=%b/%0b exp=0000/0", wb.busy_mask, wb.RegWrite);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_inputs(1, 1, 'h11, 1, 3, 'h33);
        #1;
        checks++;
        if (wb.alu_ready !== 1'b0 || wb.mem_ready !== 1'b1) begin
            errors++; $display("FAIL prio_ready got=%0b/%0b exp=0/1", wb.alu_ready, wb.mem_ready);
        end
        cycle(1, 1, 'h11, 1, 3, 'h33);
        cycle(1, 1, 'h11, 0, 0, 0);
        idle(3);
        checks++;
        if (obs.size() != 2 || obs[0].rd != 3 || obs[0].data != 'h33 || obs[1].rd != 1 || obs[1].data != 'h11) begin
            errors++; $display("FAIL prio_order got=%0d writes exp=2 (3:33 then 1:11)", obs.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(1, 0, 'hA0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 'hB1);
        cycle(1, 2, 'hC2, 0, 0, 0);
        idle(3);
        checks++;
        if (obs.size() != 3 || obs[0].data != 'hA0 || obs[1].data != 'hB1 || obs[2].data != 'hC2
            || obs[0].rd != 0 || obs[1].rd != 1 || obs[2].rd != 2) begin
            errors++; $display("FAIL b2b_order got=%0d writes exp=3 (0:a0 1:b1 2:c2)", obs.size());
        end
    endtask

    task automatic test_same_rd();
        do_reset();
`ifdef WB_BYPASS_EN
        wb.query_rd_one = 2'd0;
        wb.query_rd_two = 2'd3;
`endif
        cycle(1, 0, 'hAA, 0, 0, 0);
        cycle(1, 0, 'hBB, 0, 0, 0);
`ifdef WB_BYPASS_EN
        checks++;
        if (wb.fwd_hit_one !== 1'b1 || wb.fwd_data_one !== 8'hBB) begin
            errors++; $display("FAIL fwd_young got=%0b/%0h exp=1/bb", wb.fwd_hit_one, wb.fwd_data_one);
        end
`endif
        idle(1);
`ifdef WB_BYPASS_EN
        checks++;
        if (wb.fwd_hit_one !== 1'b1 || wb.fwd_data_one !== 8'hBB) begin
            errors++; $display("FAIL fwd_last got=%0b/%0h exp=1/bb", wb.fwd_hit_one, wb.fwd_data_one);
        end
`endif
        idle(2);
`ifdef WB_BYPASS_EN
        checks++;
        if (wb.fwd_hit_one !== 1'b0 || wb.fwd_data_one !== 8'h00) begin
            errors++; $display("FAIL fwd_retired got=%0b/%0h exp=0/00", wb.fwd_hit_one, wb.fwd_data_one);
        end
`endif
        checks++;
        if (obs.size() != 2 || obs[0].data != 'hAA || obs[1].data != 'hBB || obs[0].rd != 0 || obs[1].rd != 0) begin
            errors++; $display("FAIL same_rd got=%0d writes exp=2 (0:aa then 0:bb)", obs.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 1, 'h21, 0, 0, 0);
        cycle(0, 0, 0, 1, 2, 'h42);
        reset = 1'b1;
        set_inputs(1, 3, 'h63, 1, 3, 'h64);
        @(posedge clk);
        m_q.delete(); m_rw = 0; m_wr = 0; m_wd = 0;
        @(negedge clk);
        reset = 1'b0;
        obs.delete();
        checks++;
        if (wb.RegWrite !== 1'b0 || wb.busy_mask !== 4'b0000 || wb.pending_count !== '0) begin
            errors++; $display("FAIL mid_reset got=%0b/%b/%0d exp=0/0000/0",
                               wb.RegWrite, wb.busy_mask, wb.pending_count);
        end
        idle(4);
        checks++;
        if (obs.size() != 0) begin
            errors++; $display("FAIL mid_reset_writes got=%0d exp=0", obs.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
`ifdef WB_BYPASS_EN
            wb.query_rd_one = ADDR_W'($urandom_range(0, 3));
            wb.query_rd_two = ADDR_W'($urandom_range(0, 3));
`endif
            cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 255));
        end
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
        wb.query_rd_one = '0;
        wb.query_rd_two = '0;
`endif
        @(negedge clk);
        test_reset();
        test_latency();
        test_priority();
        test_back_to_back();
        test_same_rd();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
